// File: rtl/hazard_stall_controller.sv
// Hazard/branch-flush controller for the 5-stage vector core: tracks in-flight
// destinations in EX/MEM/WB, stalls on any RAW match, flushes on taken branches.
module hazard_stall_controller #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int WB_HAZARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              ex_br_valid,
  input  logic              ex_br_taken,
  input  logic [15:0]       ex_br_target,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              kill_ex,
  output logic              pc_load,
  output logic [15:0]       pc_target,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam bit WB_EN = (WB_HAZARD != 0);

  state_t state_q, state_d;

  logic              ex_v, mem_v, wb_v;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;

  logic match_a, match_b;
  logic hazard, flushing, br_take, stall_act;

  // Only older in-flight slots are compared, so an instruction never
  // hazards against its own rd.
  always_comb begin
    match_a = (ex_v  && (ex_rd  == id_rs_a)) ||
              (mem_v && (mem_rd == id_rs_a)) ||
              (WB_EN && wb_v && (wb_rd == id_rs_a));
    match_b = (ex_v  && (ex_rd  == id_rs_b)) ||
              (mem_v && (mem_rd == id_rs_b)) ||
              (WB_EN && wb_v && (wb_rd == id_rs_b));
  end

  assign hazard    = id_valid && ((id_use_a && match_a) || (id_use_b && match_b));
  assign flushing  = (state_q == ST_FLUSH);
  assign stall_act = hazard && !flushing;
  // EX is squashed while flushing, so a branch seen then is wrong-path.
  assign br_take   = ex_br_valid && ex_br_taken && !flushing;

  always_comb begin
    state_d = state_q;
    if (br_take) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   state_d = hazard ? ST_STALL : ST_RUN;
        ST_STALL: state_d = hazard ? ST_STALL : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_pc    = stall_act;
    stall_ifid  = stall_act;
    bubble_idex = stall_act || flushing;
    flush_ifid  = flushing;
    kill_ex     = flushing;
    pc_load     = flushing;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pc_target <= '0;
    end else begin
      state_q <= state_d;
      if (br_take) pc_target <= ex_br_target;
    end
  end

  // Slot pipeline mirrors the datapath; a killed EX never reaches MEM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_rd  <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
    end else begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v && !kill_ex;
      mem_rd <= ex_rd;
      ex_v   <= id_valid && id_wr_en && !hazard && !flushing;
      ex_rd  <= id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_act && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br_take && (flush_cnt != '1))   flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a default instance plus a
// WB-ignoring, 2-bit-counter instance, both driven by the same ID/EX stream.
module tb_hazard_stall_controller;

  logic        clk;
  logic        reset;
  logic        id_valid, id_use_a, id_use_b, id_wr_en;
  logic [4:0]  id_rs_a, id_rs_b, id_rd;
  logic        ex_br_valid, ex_br_taken;
  logic [15:0] ex_br_target;

  logic        d0_stall_pc, d0_stall_ifid, d0_bubble, d0_flush_ifid, d0_kill_ex, d0_pc_load;
  logic [15:0] d0_pc_target;
  logic [1:0]  d0_state;
  logic [15:0] d0_stall_cnt, d0_flush_cnt;

  logic        d1_stall_pc, d1_stall_ifid, d1_bubble, d1_flush_ifid, d1_kill_ex, d1_pc_load;
  logic [15:0] d1_pc_target;
  logic [1:0]  d1_state;
  logic [1:0]  d1_stall_cnt, d1_flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .stall_pc(d0_stall_pc), .stall_ifid(d0_stall_ifid), .bubble_idex(d0_bubble),
    .flush_ifid(d0_flush_ifid), .kill_ex(d0_kill_ex), .pc_load(d0_pc_load),
    .pc_target(d0_pc_target), .state(d0_state), .stall_cnt(d0_stall_cnt), .flush_cnt(d0_flush_cnt)
  );

  hazard_stall_controller #(.CNT_W(2), .WB_HAZARD(0)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .stall_pc(d1_stall_pc), .stall_ifid(d1_stall_ifid), .bubble_idex(d1_bubble),
    .flush_ifid(d1_flush_ifid), .kill_ex(d1_kill_ex), .pc_load(d1_pc_load),
    .pc_target(d1_pc_target), .state(d1_state), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub,
                        input logic [4:0] rd, input logic we);
    id_valid = v; id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
    id_rd = rd; id_wr_en = we;
  endtask

  task automatic set_br(input logic v, input logic t, input logic [15:0] tgt);
    ex_br_valid = v; ex_br_taken = t; ex_br_target = tgt;
  endtask

  initial begin
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_br(0, 0, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    look();
    chk("rst_state", d0_state, 0);
    chk("rst_stall", d0_stall_pc, 0);
    chk("rst_flush", d0_flush_ifid, 0);
    chk("rst_kill", d0_kill_ex, 0);
    chk("rst_pcload", d0_pc_load, 0);
    chk("rst_target", d0_pc_target, 0);
    chk("rst_scnt", d0_stall_cnt, 0);
    chk("rst_fcnt", d0_flush_cnt, 0);
    tick();

    // Writer r5, then a dependent reader held in ID until it issues.
    set_id(1, 0, 0, 0, 0, 5, 1); look();
    chk("a0_stall_d0", d0_stall_pc, 0);
    chk("a0_stall_d1", d1_stall_pc, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 7, 1); look();
    chk("a1_stall_d0", d0_stall_pc, 1);
    chk("a1_stall_d1", d1_stall_pc, 1);
    chk("a1_ifid_d0", d0_stall_ifid, 1);
    chk("a1_bubble_d0", d0_bubble, 1);
    chk("a1_state_d0", d0_state, 0);
    tick(); look();
    chk("a2_stall_d0", d0_stall_pc, 1);
    chk("a2_stall_d1", d1_stall_pc, 1);
    chk("a2_state_d0", d0_state, 1);
    chk("a2_state_d1", d1_state, 1);
    chk("a2_scnt_d0", d0_stall_cnt, 1);
    chk("a2_scnt_d1", d1_stall_cnt, 1);
    tick(); look();
    chk("a3_stall_d0", d0_stall_pc, 1);
    chk("a3_stall_d1", d1_stall_pc, 0);
    chk("a3_bubble_d1", d1_bubble, 0);
    chk("a3_scnt_d0", d0_stall_cnt, 2);
    tick(); look();
    chk("a4_stall_d0", d0_stall_pc, 0);
    chk("a4_stall_d1", d1_stall_pc, 0);
    chk("a4_scnt_d0", d0_stall_cnt, 3);
    chk("a4_scnt_d1", d1_stall_cnt, 2);
    chk("a4_state_d0", d0_state, 1);
    chk("a4_state_d1", d1_state, 0);
    tick();
    // Independent r6 reader/writer: no self-hazard, no stall.
    set_id(1, 6, 1, 6, 1, 6, 1); look();
    chk("a5_stall_d0", d0_stall_pc, 0);
    chk("a5_stall_d1", d1_stall_pc, 0);
    chk("a5_state_d0", d0_state, 0);
    tick();
    set_id(0, 6, 1, 6, 1, 6, 1); look();
    chk("a6_novalid_d0", d0_stall_pc, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Taken branch to 0x0040; wrong-path r3 writer must be squashed.
    set_id(1, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 3, 1);
    set_br(1, 1, 16'h0040); look();
    chk("b1_pcload_d0", d0_pc_load, 0);
    chk("b1_state_d0", d0_state, 0);
    tick();
    set_id(1, 3, 1, 0, 0, 8, 0);
    set_br(1, 1, 16'h0080); look();
    chk("b2_state_d0", d0_state, 2);
    chk("b2_pcload_d0", d0_pc_load, 1);
    chk("b2_target_d0", d0_pc_target, 16'h0040);
    chk("b2_flush_d0", d0_flush_ifid, 1);
    chk("b2_kill_d0", d0_kill_ex, 1);
    chk("b2_bubble_d0", d0_bubble, 1);
    chk("b2_stall_d0", d0_stall_pc, 0);
    chk("b2_fcnt_d0", d0_flush_cnt, 1);
    chk("b2_state_d1", d1_state, 2);
    tick();
    set_br(0, 0, 16'h0000); look();
    chk("b3_state_d0", d0_state, 0);
    chk("b3_pcload_d0", d0_pc_load, 0);
    chk("b3_target_d0", d0_pc_target, 16'h0040);
    chk("b3_fcnt_d0", d0_flush_cnt, 1);
    chk("b3_stall_d0", d0_stall_pc, 0);
    chk("b3_stall_d1", d1_stall_pc, 0);
    chk("b3_scnt_d0", d0_stall_cnt, 3);
    tick();

    // Hazard in ID on the edge a taken branch is sampled.
    set_id(1, 0, 0, 0, 0, 9, 1); tick();
    set_id(1, 0, 0, 9, 1, 2, 0);
    set_br(1, 1, 16'h1234); look();
    chk("c1_stall_d0", d0_stall_pc, 1);
    chk("c1_stall_d1", d1_stall_pc, 1);
    tick();
    set_br(0, 0, 16'h0000); look();
    chk("c2_state_d0", d0_state, 2);
    chk("c2_stall_d0", d0_stall_pc, 0);
    chk("c2_ifid_d0", d0_stall_ifid, 0);
    chk("c2_bubble_d0", d0_bubble, 1);
    chk("c2_target_d0", d0_pc_target, 16'h1234);
    chk("c2_fcnt_d0", d0_flush_cnt, 2);
    chk("c2_scnt_d0", d0_stall_cnt, 4);
    chk("c2_scnt_d1", d1_stall_cnt, 3);
    tick(); look();
    chk("c3_state_d0", d0_state, 0);
    chk("c3_scnt_d0", d0_stall_cnt, 4);
    chk("c3_stall_d0", d0_stall_pc, 1);
    chk("c3_stall_d1", d1_stall_pc, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); look();
    chk("c4_scnt_d0", d0_stall_cnt, 5);
    chk("c4_state_d0", d0_state, 1);
    tick(); tick(); tick();

    // Second dependency while the 2-bit counter is already at its ceiling.
    set_id(1, 0, 0, 0, 0, 1, 1); tick();
    set_id(1, 1, 1, 0, 0, 2, 0); look();
    chk("d1_stall_d1", d1_stall_pc, 1);
    tick(); look();
    chk("d2_stall_d1", d1_stall_pc, 1);
    tick(); look();
    chk("d3_stall_d0", d0_stall_pc, 1);
    chk("d3_stall_d1", d1_stall_pc, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); look();
    chk("d4_scnt_d0", d0_stall_cnt, 8);
    chk("d4_scnt_sat_d1", d1_stall_cnt, 3);
    tick(); tick(); tick();

    // Reset asserted mid-stall.
    set_id(1, 0, 0, 0, 0, 4, 1); tick();
    set_id(1, 4, 1, 0, 0, 5, 0); look();
    chk("e1_stall_d0", d0_stall_pc, 1);
    tick(); look();
    chk("e2_state_d0", d0_state, 1);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1; look();
    chk("e3_stall_d0", d0_stall_pc, 0);
    chk("e3_bubble_d0", d0_bubble, 0);
    chk("e3_state_d0", d0_state, 0);
    chk("e3_scnt_d0", d0_stall_cnt, 0);
    chk("e3_fcnt_d0", d0_flush_cnt, 0);
    chk("e3_target_d0", d0_pc_target, 0);
    chk("e3_stall_d1", d1_stall_pc, 0);
    chk("e3_scnt_d1", d1_stall_cnt, 0);
    tick(); look();
    chk("e4_stall_d0", d0_stall_pc, 0);
    chk("e4_scnt_d0", d0_stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
